cpu_program_loader: RTL and testbench

- Sequencer for the single-cycle CPU's program load and run cycle.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and drives the CPU's initialize, instruction_initialize_data and instruction_initialize_address inputs to write them at consecutive word addresses.
- After loading, releases the CPU from reset for a programmed number of cycles, then holds it in reset again.
- Replaces hand-timed load sequences in benches and on-board bring-up.

---
 rtl/cpu_program_loader.sv | 127 ++++++++++++
 tb/tb_cpu_program_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_loader.sv
// Program load / run sequencer for the single-cycle CPU: streams instruction words into
// instruction memory, releases the CPU for a fixed cycle budget, then parks it in reset.
module cpu_program_loader #(
  parameter int unsigned IMEM_WORDS = 32,
  parameter int unsigned RUN_W      = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic [31:0]      word_data,
  input  logic             word_last,
  input  logic             halt,
  output logic             cpu_rst,
  output logic             cpu_initialize,
  output logic [31:0]      cpu_init_data,
  output logic [31:0]      cpu_init_address,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {StIdle, StLoad, StSettle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] budget_q, budget_d;
  logic [RUN_W-1:0] cnt_q, cnt_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             cpu_init_q, cpu_init_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      addr_q, addr_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] wl_q, wl_d;
  logic             accept;

  assign word_ready       = (state_q == StLoad);
  assign busy             = (state_q == StLoad) || (state_q == StSettle) || (state_q == StRun);
  assign accept           = word_valid && word_ready;
  assign cpu_rst          = cpu_rst_q;
  assign cpu_initialize   = cpu_init_q;
  assign cpu_init_data    = data_q;
  assign cpu_init_address = addr_q;
  assign done             = done_q;
  assign overflow         = ovf_q;
  assign words_loaded     = wl_q;

  always_comb begin
    state_d  = state_q;
    budget_d = budget_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    addr_d   = addr_q;
    ovf_d    = ovf_q;
    wl_d     = wl_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          budget_d = run_cycles;
          wl_d     = '0;
          ovf_d    = 1'b0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          data_d = word_data;
          addr_d = 32'(wl_q) << 2;
          wl_d   = wl_q + CNT_W'(1);
          if (word_last) begin
            state_d = StSettle;
          end else if (wl_q == CNT_W'(IMEM_WORDS - 1)) begin
            // Memory full without a terminator: never let the CPU run a truncated program.
            ovf_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StSettle: begin
        cnt_d   = '0;
        state_d = (budget_q == '0) ? StDone : StRun;
      end
      StRun: begin
        cnt_d = cnt_q + RUN_W'(1);
        if (halt || (cnt_q == budget_q - RUN_W'(1))) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered from the next state so cpu_rst is low exactly for the cycles spent in RUN.
    cpu_rst_d  = (state_d != StRun);
    cpu_init_d = (state_d != StRun);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      budget_q   <= '0;
      cnt_q      <= '0;
      cpu_rst_q  <= 1'b1;
      cpu_init_q <= 1'b1;
      data_q     <= '0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wl_q       <= '0;
    end else begin
      state_q    <= state_d;
      budget_q   <= budget_d;
      cnt_q      <= cnt_d;
      cpu_rst_q  <= cpu_rst_d;
      cpu_init_q <= cpu_init_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      wl_q       <= wl_d;
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Self-checking bench for cpu_program_loader: a scoreboard of expected address/data writes
// plus per-scenario tasks checking run length, overflow, halt and reset behaviour.
module tb_cpu_program_loader;
  localparam int unsigned IMEM = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] run_cycles = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [31:0] word_data = '0;
  logic        word_last = 1'b0;
  logic        halt = 1'b0;
  logic        cpu_rst, cpu_initialize, busy, done, overflow;
  logic [31:0] cpu_init_data, cpu_init_address;
  logic [15:0] words_loaded;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_pair = '0;
  logic [63:0] exp_e;
  bit          mon_en = 1'b0;
  bit          acc_n = 1'b0;
  bit          rst_low_seen = 1'b0;
  int          model_cnt = 0;
  logic [31:0] prog[6] = '{32'h00022020, 32'h00110113, 32'h00208193,
                           32'h00000003, 32'h00000004, 32'h00000005};

  cpu_program_loader #(.IMEM_WORDS(IMEM), .RUN_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .run_cycles(run_cycles),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .word_last(word_last), .halt(halt), .cpu_rst(cpu_rst), .cpu_initialize(cpu_initialize),
    .cpu_init_data(cpu_init_data), .cpu_init_address(cpu_init_address), .busy(busy),
    .done(done), .overflow(overflow), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input int i);
    return (i < 6) ? prog[i] : 32'hA000_0000 + 32'(i);
  endfunction

  always @(negedge clk) begin
    acc_n = word_valid && word_ready && !rst;
    if (cpu_rst === 1'b0) rst_low_seen = 1'b1;
  end

  // Every accepted word must show up as the next scoreboard entry; otherwise the pair holds.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      vectors++;
      if (acc_n) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_accept: got addr=%h data=%h, expected no write",
                   cpu_init_address, cpu_init_data);
          last_pair = {cpu_init_address, cpu_init_data};
        end else begin
          exp_e = exp_q.pop_front();
          if ({cpu_init_address, cpu_init_data} !== exp_e) begin
            miscompares++;
            $display("FAIL write_pair: got addr=%h data=%h, expected addr=%h data=%h",
                     cpu_init_address, cpu_init_data, exp_e[63:32], exp_e[31:0]);
          end
          last_pair = exp_e;
        end
      end else if ({cpu_init_address, cpu_init_data} !== last_pair) begin
        miscompares++;
        $display("FAIL pair_hold: got addr=%h data=%h, expected addr=%h data=%h",
                 cpu_init_address, cpu_init_data, last_pair[63:32], last_pair[31:0]);
        last_pair = {cpu_init_address, cpu_init_data};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic start_load(input logic [15:0] b);
    start = 1'b1;
    run_cycles = b;
    @(posedge clk); #1;
    start = 1'b0;
    run_cycles = 16'($urandom);
    model_cnt = 0;
  endtask

  task automatic send_words(input int first, input int n, input int gmax, input bit last_flag);
    for (int i = 0; i < n; i++) begin
      int g;
      bit ok;
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      word_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      word_valid = 1'b1;
      word_data  = word_at(first + i);
      word_last  = last_flag && (i == n - 1);
      exp_q.push_back({32'(4 * model_cnt), word_at(first + i)});
      model_cnt++;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        if (word_ready === 1'b1) ok = 1'b1;
        @(posedge clk); #1;
      end
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: word %0d never accepted, expected word_ready=1", i);
      end
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
  endtask

  // Entered one cycle after the final word is accepted (SETTLE); measures the RUN window.
  task automatic check_run(input int exp_low);
    int low;
    @(negedge clk);
    chk("settle_busy", 32'(busy), 1);
    chk("settle_ready", 32'(word_ready), 0);
    chk("settle_cpu_rst", 32'(cpu_rst), 1);
    low = 0;
    for (int k = 0; k < exp_low + 50; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (cpu_rst === 1'b0) low++;
      if (cpu_initialize !== cpu_rst) chk("init_tracks_rst", 32'(cpu_initialize), 32'(cpu_rst));
    end
    chk("run_length", 32'(low), 32'(exp_low));
    chk("done_after_run", 32'(done), 1);
    chk("cpu_rst_after_run", 32'(cpu_rst), 1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin
      start = 1'($urandom); word_valid = 1'($urandom); halt = 1'($urandom);
      word_data = $urandom; word_last = 1'($urandom); run_cycles = 16'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_cpu_init", 32'(cpu_initialize), 1);
    chk("rst_data", cpu_init_data, 0);
    chk("rst_addr", cpu_init_address, 0);
    chk("rst_flags", {29'd0, busy, done, overflow}, 0);
    chk("rst_words", 32'(words_loaded), 0);
    chk("rst_ready", 32'(word_ready), 0);
    @(posedge clk); #1;
    start = 0; word_valid = 0; halt = 0; word_last = 0; rst = 1'b0;
    last_pair = '0;
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    start_load(16'd30);
    send_words(0, 6, 0, 1'b1);
    check_run(30);
    chk("basic_words", 32'(words_loaded), 6);
    chk("basic_overflow", 32'(overflow), 0);
    chk("basic_sb_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic test_backpressure;
    start_load(16'd3);
    send_words(0, 6, 3, 1'b1);
    check_run(3);
    chk("bp_words", 32'(words_loaded), 6);
    chk("bp_sb_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic test_overflow;
    start_load(16'd50);
    rst_low_seen = 1'b0;
    send_words(0, IMEM, 1, 1'b0);
    @(negedge clk);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_done", 32'(done), 1);
    chk("ovf_ready", 32'(word_ready), 0);
    chk("ovf_words", 32'(words_loaded), IMEM);
    chk("ovf_last_addr", cpu_init_address, 28);
    @(posedge clk); #1;
    for (int i = IMEM; i < IMEM + 2; i++) begin
      word_valid = 1'b1;
      word_data  = word_at(i);
      repeat (3) begin @(negedge clk); chk("ovf_ready_extra", 32'(word_ready), 0); end
      @(posedge clk); #1;
    end
    word_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("ovf_cpu_never_run", 32'(rst_low_seen), 0);
    chk("ovf_sb_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic test_halt;
    int low;
    start_load(16'd100);
    send_words(0, 2, 0, 1'b1);
    @(posedge clk); #1;
    low = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (cpu_rst === 1'b0) low++;
      if (c == 5) halt = 1'b1;
      @(posedge clk); #1;
    end
    halt = 1'b0;
    @(negedge clk);
    chk("halt_low_cycles", 32'(low), 5);
    chk("halt_cpu_rst", 32'(cpu_rst), 1);
    chk("halt_done", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic test_zero_budget;
    start_load(16'd0);
    rst_low_seen = 1'b0;
    send_words(0, 1, 0, 1'b1);
    check_run(0);
    repeat (5) begin @(posedge clk); #1; end
    chk("zero_never_run", 32'(rst_low_seen), 0);
    chk("zero_words", 32'(words_loaded), 1);
  endtask

  task automatic test_reset_restart;
    start_load(16'd100);
    send_words(0, 2, 0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_run_cpu_rst", 32'(cpu_rst), 0);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_words", 32'(words_loaded), 0);
    chk("mid_rst_addr", cpu_init_address, 0);
    exp_q.delete();
    last_pair = '0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start_load(16'd4);
    send_words(0, 2, 0, 1'b0);
    start = 1'b1;
    run_cycles = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    send_words(2, 1, 0, 1'b1);
    check_run(4);
    chk("restart_words", 32'(words_loaded), 3);
    chk("restart_sb_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_halt();
    test_zero_budget();
    test_reset_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
